// File: rtl/reference_buffer_burst_if.sv
// Load, swap, command and sample-stream signals of the burst reference buffer.
// master drives loads/commands/rd_ready; slave is the buffer itself.
interface reference_buffer_burst_if #(
    parameter int INDEX_BITS = 4,
    parameter int LEN_BITS   = 8,
    parameter int I_BITS     = 12,
    parameter int Q_BITS     = 12
);
    logic                           wr_valid;
    logic                           wr_ready;
    logic [I_BITS+Q_BITS-1:0]       wr_data;
    logic                           wr_last;
    logic                           swap_req;
    logic                           swap_ack;
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [INDEX_BITS-1:0]          cmd_addr;
    logic [LEN_BITS-1:0]            cmd_len;
    logic                           cmd_err;
    logic                           rd_valid;
    logic                           rd_ready;
    logic signed [I_BITS-1:0]       i;
    logic signed [Q_BITS-1:0]       q;
    logic                           rd_last;
    logic                           busy;

    modport master (
        output wr_valid, wr_data, wr_last, swap_req, cmd_valid, cmd_addr, cmd_len, rd_ready,
        input  wr_ready, swap_ack, cmd_ready, cmd_err, rd_valid, i, q, rd_last, busy
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, swap_req, cmd_valid, cmd_addr, cmd_len, rd_ready,
        output wr_ready, swap_ack, cmd_ready, cmd_err, rd_valid, i, q, rd_last, busy
    );
endinterface

// File: rtl/reference_buffer_burst.sv
// Double-banked I/Q reference store serving wrap-around bursts over ready/valid.
// Bank 0 powers up holding INIT_BANK0; loads fill the shadow bank, swapped in between bursts.
module reference_buffer_burst #(
    parameter int BUFFER_LENGTH = 10,
    parameter int INDEX_BITS    = 4,
    parameter int LEN_BITS      = 8,
    parameter int I_BITS        = 12,
    parameter int Q_BITS        = 12,
    parameter logic [BUFFER_LENGTH*(I_BITS+Q_BITS)-1:0] INIT_BANK0 = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    reference_buffer_burst_if.slave bus
);
    localparam int W      = I_BITS + Q_BITS;
    localparam int ADDR_W = $clog2(2 * BUFFER_LENGTH);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Both banks live in one array: bank 0 at words 0..L-1, bank 1 at L..2L-1.
    logic [2*BUFFER_LENGTH-1:0][W-1:0] r_mem = {{(BUFFER_LENGTH*W){1'b0}}, INIT_BANK0};

    logic                  r_alive;
    logic                  r_active_bank;
    logic                  r_shadow_valid;
    logic                  r_swap_pending;
    logic [INDEX_BITS-1:0] r_wr_ptr;
    logic [INDEX_BITS-1:0] r_rd_addr;
    logic [LEN_BITS-1:0]   r_remaining;
    logic                  r_rd_pend;
    logic [W-1:0]          r_ram_q;
    logic                  r_ram_last;
    logic [W-1:0]          r_fifo_q [2];
    logic                  r_fifo_last [2];
    logic                  r_fifo_wp;
    logic                  r_fifo_rp;
    logic [1:0]            r_fifo_cnt;

    logic                  w_out_pending;
    logic                  w_swap;
    logic                  w_wr_rdy;
    logic                  w_cmd_rdy;
    logic                  w_wr_acc;
    logic                  w_cmd_acc;
    logic                  w_cmd_bad;
    logic                  w_cmd_go;
    logic                  w_rd_valid;
    logic                  w_pop;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_last_issue;
    logic [ADDR_W-1:0]     w_wr_idx;
    logic [ADDR_W-1:0]     w_rd_idx;

    assign w_out_pending = r_rd_pend | (r_fifo_cnt != 2'd0);
    assign w_swap        = r_swap_pending & r_shadow_valid & (r_state == S_IDLE) & ~w_out_pending;
    assign w_wr_rdy      = r_alive & ~w_swap;
    assign w_cmd_rdy     = r_alive & (r_state == S_IDLE) & ~w_swap;
    assign w_wr_acc      = bus.wr_valid & w_wr_rdy;
    assign w_cmd_acc     = bus.cmd_valid & w_cmd_rdy;
    assign w_cmd_bad     = 32'(bus.cmd_addr) >= BUFFER_LENGTH;
    assign w_cmd_go      = w_cmd_acc & ~w_cmd_bad & (bus.cmd_len != '0);
    assign w_rd_valid    = r_fifo_cnt != 2'd0;
    assign w_pop         = w_rd_valid & bus.rd_ready;

    // Credit counts the slot freed by this cycle's pop so a full-rate stream has no bubbles.
    assign w_credit      = (({1'b0, r_fifo_cnt} + {2'b00, r_rd_pend}) - {2'b00, w_pop}) < 3'd2;
    assign w_issue       = (r_state == S_BURST) & w_credit;
    assign w_last_issue  = w_issue & (r_remaining == LEN_BITS'(1));

    assign w_wr_idx = r_active_bank ? ADDR_W'(r_wr_ptr)
                                    : ADDR_W'(r_wr_ptr) + ADDR_W'(BUFFER_LENGTH);
    assign w_rd_idx = r_active_bank ? ADDR_W'(r_rd_addr) + ADDR_W'(BUFFER_LENGTH)
                                    : ADDR_W'(r_rd_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_go) w_state_nxt = S_BURST;
            S_BURST: if (w_last_issue) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.wr_ready  = w_wr_rdy;
        bus.cmd_ready = w_cmd_rdy;
        bus.cmd_err   = w_cmd_acc & w_cmd_bad;
        bus.swap_ack  = w_swap;
        bus.rd_valid  = w_rd_valid;
        bus.i         = w_rd_valid ? r_fifo_q[r_fifo_rp][W-1:Q_BITS] : '0;
        bus.q         = w_rd_valid ? r_fifo_q[r_fifo_rp][Q_BITS-1:0] : '0;
        bus.rd_last   = w_rd_valid & r_fifo_last[r_fifo_rp];
        bus.busy      = (r_state == S_BURST) | w_out_pending;
    end

    // Load / bank control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive        <= 1'b0;
            r_active_bank  <= 1'b0;
            r_shadow_valid <= 1'b0;
            r_swap_pending <= 1'b0;
            r_wr_ptr       <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_swap) begin
                r_active_bank  <= ~r_active_bank;
                r_shadow_valid <= 1'b0;
                r_swap_pending <= 1'b0;
            end else if (bus.swap_req) begin
                r_swap_pending <= 1'b1;
            end
            if (w_wr_acc) begin
                if (bus.wr_last) begin
                    r_wr_ptr       <= '0;
                    r_shadow_valid <= 1'b1;
                end else begin
                    r_wr_ptr       <= (r_wr_ptr == INDEX_BITS'(BUFFER_LENGTH - 1))
                                      ? '0 : r_wr_ptr + INDEX_BITS'(1);
                    r_shadow_valid <= 1'b0;
                end
            end
        end
    end

    // Read issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_rd_pend   <= 1'b0;
        end else begin
            r_rd_pend <= w_issue;
            if (r_state == S_IDLE && w_cmd_go) begin
                r_rd_addr   <= bus.cmd_addr;
                r_remaining <= bus.cmd_len;
            end else if (w_issue) begin
                r_rd_addr   <= (r_rd_addr == INDEX_BITS'(BUFFER_LENGTH - 1))
                               ? '0 : r_rd_addr + INDEX_BITS'(1);
                r_remaining <= r_remaining - LEN_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[w_wr_idx] <= bus.wr_data;
        if (w_issue) begin
            r_ram_q    <= r_mem[w_rd_idx];
            r_ram_last <= r_remaining == LEN_BITS'(1);
        end
    end

    // Skid FIFO behind the RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_wp  <= 1'b0;
            r_fifo_rp  <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (r_rd_pend) r_fifo_wp <= ~r_fifo_wp;
            if (w_pop)     r_fifo_rp <= ~r_fifo_rp;
            r_fifo_cnt <= (r_fifo_cnt + {1'b0, r_rd_pend}) - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (r_rd_pend) begin
            r_fifo_q[r_fifo_wp]    <= r_ram_q;
            r_fifo_last[r_fifo_wp] <= r_ram_last;
        end
    end
endmodule

// File: tb/tb_reference_buffer_burst.sv
// Directed bench for reference_buffer_burst: table of bursts plus load/swap and reset sequences.
module tb_reference_buffer_burst;
    localparam int L  = 10;
    localparam int IB = 4;
    localparam int LB = 8;
    localparam int IW = 12;
    localparam int QW = 12;
    localparam int W  = IW + QW;

    // Bank 0 word k: I = 16k-1, Q = 5-7k.  Loaded bank word k: I = -200-k, Q = 300+k.
    function automatic logic [W-1:0] word(input int bank, input int k);
        logic signed [IW-1:0] iv;
        logic signed [QW-1:0] qv;
        if (bank == 0) begin
            iv = IW'(16 * k - 1);
            qv = QW'(5 - 7 * k);
        end else begin
            iv = IW'(-200 - k);
            qv = QW'(300 + k);
        end
        return {iv, qv};
    endfunction

    function automatic logic [L*W-1:0] img0();
        logic [L*W-1:0] r;
        r = '0;
        for (int k = 0; k < L; k++) r[k*W +: W] = word(0, k);
        return r;
    endfunction

    localparam logic [L*W-1:0] IMG0 = img0();

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   burst_done;

    reference_buffer_burst_if #(.INDEX_BITS(IB), .LEN_BITS(LB), .I_BITS(IW), .Q_BITS(QW)) bus ();

    reference_buffer_burst #(
        .BUFFER_LENGTH(L), .INDEX_BITS(IB), .LEN_BITS(LB),
        .I_BITS(IW), .Q_BITS(QW), .INIT_BANK0(IMG0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        int         len;
        bit         err;
        logic [5:0] pat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_burst(input int addr, input int len, input bit exp_err,
                            input int bank, input logic [5:0] pat);
        int          n;
        int          k;
        int          cyc;
        int          first;
        bit          stalled;
        logic [31:0] held;
        logic [31:0] now_v;
        bit          full;
        full = (pat == 6'h3F);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = IB'(addr);
        bus.cmd_len   = LB'(len);
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("cmd_err", 32'(bus.cmd_err), 32'(exp_err));
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (exp_err || len == 0) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("no_output", 32'({bus.rd_valid, bus.busy, bus.cmd_err}), 32'd0);
                chk("cmd_ready_next", 32'(bus.cmd_ready), 32'd1);
                @(posedge clk); #1;
            end
        end else begin
            k = 0; cyc = 0; first = -1; stalled = 1'b0; held = '0;
            while (k < len && cyc < 300) begin
                bus.rd_ready = pat[cyc % 6];
                @(negedge clk);
                now_v = 32'({bus.rd_valid, bus.rd_last, bus.i, bus.q});
                if (stalled) chk("stall_hold", now_v, held);
                if (bus.rd_valid && first < 0) first = cyc;
                stalled = 1'b0;
                if (bus.rd_valid && bus.rd_ready) begin
                    chk("sample", 32'({bus.i, bus.q}), 32'(word(bank, (addr + k) % L)));
                    chk("rd_last", 32'(bus.rd_last), 32'(k == len - 1));
                    k++;
                end else if (bus.rd_valid) begin
                    held    = now_v;
                    stalled = 1'b1;
                end
                @(posedge clk); #1;
                cyc++;
            end
            bus.rd_ready = 1'b1;
            chk("burst_count", 32'(k), 32'(len));
            if (full) begin
                chk("first_latency", 32'(first), 32'd2);
                chk("burst_cycles", 32'(cyc), 32'(len + 2));
            end
            burst_done = 1'b1;
            @(negedge clk);
            chk("post_idle", 32'({bus.rd_valid, bus.busy}), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        burst_done = 1'b0;
        rst_n = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_last = 1'b0;
        bus.swap_req = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_addr = '0;
        bus.cmd_len = '0; bus.rd_ready = 1'b1;

        vecs[0] = '{addr: 3,  len: 4,  err: 1'b0, pat: 6'h3F};
        vecs[1] = '{addr: 8,  len: 5,  err: 1'b0, pat: 6'h3F};
        vecs[2] = '{addr: 12, len: 3,  err: 1'b1, pat: 6'h3F};
        vecs[3] = '{addr: 0,  len: 0,  err: 1'b0, pat: 6'h3F};
        vecs[4] = '{addr: 5,  len: 6,  err: 1'b0, pat: 6'b101001};
        vecs[5] = '{addr: 9,  len: 12, err: 1'b0, pat: 6'h3F};
        vecs[6] = '{addr: 15, len: 1,  err: 1'b1, pat: 6'h3F};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_flags", 32'({bus.swap_ack, bus.cmd_err, bus.rd_valid, bus.rd_last, bus.busy}), 32'd0);
        chk("rst_iq", 32'({bus.i, bus.q}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("alive_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("alive_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++)
            do_burst(vecs[v].addr, vecs[v].len, vecs[v].err, 0, vecs[v].pat);

        // Load the shadow bank and request a swap while a stalled burst is still running.
        burst_done = 1'b0;
        fork
            do_burst(0, 10, 1'b0, 0, 6'b101001);
            begin
                repeat (3) begin @(posedge clk); #1; end
                for (int k = 0; k < L; k++) begin
                    bus.wr_valid = 1'b1;
                    bus.wr_data  = word(1, k);
                    bus.wr_last  = (k == L - 1);
                    @(negedge clk);
                    chk("wr_ready_load", 32'(bus.wr_ready), 32'd1);
                    @(posedge clk); #1;
                end
                bus.wr_valid = 1'b0;
                bus.wr_last  = 1'b0;
                bus.swap_req = 1'b1;
                @(negedge clk);
                chk("busy_at_swap_req", 32'(bus.busy), 32'd1);
                @(posedge clk); #1;
                bus.swap_req = 1'b0;
            end
            begin
                int c;
                c = 0;
                @(negedge clk);
                while (!bus.swap_ack && c < 300) begin
                    @(negedge clk);
                    c++;
                end
                chk("swap_ack_seen", 32'(bus.swap_ack), 32'd1);
                chk("swap_after_last", 32'(burst_done), 32'd1);
                chk("swap_cmd_ready", 32'(bus.cmd_ready), 32'd0);
                @(negedge clk);
                chk("swap_ack_pulse", 32'(bus.swap_ack), 32'd0);
            end
        join
        @(posedge clk); #1;
        do_burst(2, 3, 1'b0, 1, 6'h3F);
        do_burst(8, 4, 1'b0, 1, 6'h3F);

        // Asynchronous reset while samples are streaming.
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = IB'(1);
        bus.cmd_len   = LB'(8);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.rd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_burst_valid", 32'(bus.rd_valid), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs",
            32'({bus.rd_valid, bus.rd_last, bus.busy, bus.cmd_ready, bus.wr_ready,
                 bus.swap_ack, bus.cmd_err, bus.i, bus.q}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_burst(0, 2, 1'b0, 0, 6'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
